// File: rtl/barcode_pkg.sv
// rtl/barcode_pkg.sv - shared types, ASCII codes and EAN-13 check helper for the barcode UART reporter
package barcode_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [7:0] ASCII_ZERO     = 8'h30;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_QM       = 8'h3F;
    localparam logic [7:0] ASCII_Y        = 8'h59;
    localparam logic [7:0] ASCII_N        = 8'h4E;
    localparam int         FRAME_LEN_BASE = 15;

    function automatic logic [7:0] digit_ascii(input digit_t d);
        return (d > 4'd9) ? ASCII_QM : (ASCII_ZERO + {4'h0, d});
    endfunction

`ifdef BARCODE_CHECKSUM_EN
    // Weighted sum wraps at 8 bits; any undecodable digit forces a mismatch.
    function automatic logic ean_check_ok(input logic [12:0][3:0] d);
        logic [7:0] s;
        logic       bad;
        logic [3:0] want;
        s   = 8'h00;
        bad = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (d[i] > 4'd9) bad = 1'b1;
        end
        for (int i = 0; i < 12; i++) begin
            s = s + (((i % 2) == 1) ? (8'(d[i]) * 8'd3) : 8'(d[i]));
        end
        want = 4'((8'd10 - (s % 8'd10)) % 8'd10);
        return !bad && (want == d[12]);
    endfunction
`endif

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 byte serializer; tready in the last stop-bit cycle allows gapless bytes
module uart_byte_tx #(
    parameter int BIT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tdata,
    input  logic       tvalid,
    output logic       tready,
    output logic       uart_tx
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;
    logic          last_cyc;

    assign last_cyc = active && (bit_idx == 4'd9) && (cnt == CNT_LAST);
    assign tready   = !active || last_cyc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uart_tx <= 1'b1;
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= 4'd0;
            shreg   <= 9'h000;
        end else if (tvalid && tready) begin
            // shreg holds the remaining data bits followed by the stop bit
            uart_tx <= 1'b0;
            shreg   <= {1'b1, tdata};
            active  <= 1'b1;
            cnt     <= '0;
            bit_idx <= 4'd0;
        end else if (active) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active  <= 1'b0;
                    uart_tx <= 1'b1;
                end else begin
                    uart_tx <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/barcode_uart_report.sv
// rtl/barcode_uart_report.sv - captures 13 EAN-13 digits and reports them over UART; BARCODE_CHECKSUM_EN adds a Y/N check byte
module barcode_uart_report
    import barcode_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_en,
    input  logic [12:0][3:0] scan_data,
    output logic             uart_tx,
    output logic             tx_busy,
    output logic             frame_done
);

    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
`ifdef BARCODE_CHECKSUM_EN
    localparam int LEN = FRAME_LEN_BASE + 1;
`else
    localparam int LEN = FRAME_LEN_BASE;
`endif
    localparam logic [3:0] LAST_IDX = 4'(LEN - 1);
    localparam logic [3:0] IDX_CR   = 4'(LEN - 2);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       byte_sel;
    logic [12:0][3:0] digits_q;
    logic             scan_en_d;
    logic             capture;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
`ifdef BARCODE_CHECKSUM_EN
    logic             chk_ok_q;
`endif

    assign tx_busy    = (state_q == ST_LOAD) || (state_q == ST_SEND);
    assign frame_done = (state_q == ST_DONE);
    assign capture    = scan_en_d && !scan_en && !tx_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            scan_en_d <= 1'b0;
            digits_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            scan_en_d <= scan_en;
            if (capture) digits_q <= scan_data;
        end
    end

`ifdef BARCODE_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) chk_ok_q <= 1'b0;
        else if (state_q == ST_LOAD) chk_ok_q <= ean_check_ok(digits_q);
    end
`endif

    // The next byte is offered in the stop-bit tail of the current one, so bytes run gapless.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tx_valid = 1'b0;
        byte_sel = idx_q;
        case (state_q)
            ST_IDLE: if (capture) state_d = ST_LOAD;
            ST_LOAD: begin
                tx_valid = 1'b1;
                byte_sel = 4'd0;
                idx_d    = 4'd0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        tx_valid = 1'b1;
                        byte_sel = idx_q + 4'd1;
                        idx_d    = idx_q + 4'd1;
                    end
                end
            end
            ST_DONE: state_d = capture ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_data = ASCII_LF;
        if (byte_sel < 4'd13) tx_data = digit_ascii(digits_q[byte_sel]);
        else if (byte_sel == IDX_CR) tx_data = ASCII_CR;
`ifdef BARCODE_CHECKSUM_EN
        else if (byte_sel == 4'd13) tx_data = chk_ok_q ? ASCII_Y : ASCII_N;
`endif
    end

    uart_byte_tx #(
        .BIT_CYC(BIT_CYC)
    ) u_byte_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tdata   (tx_data),
        .tvalid  (tx_valid),
        .tready  (tx_ready),
        .uart_tx (uart_tx)
    );

endmodule
